// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // OR-reduction encode; valid only for one-hot or all-zero inputs.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin picker: first set request at or after ptr (mod 8).
// Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate the index back.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;
  logic [SEL_W-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
    first = rot & (~rot + N_REQ'(1));
    off   = onehot_to_idx(first);
    found = |req;
    idx   = ptr + off;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Lock-style round-robin arbiter driving the select lines of an 8:1 mux.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles when others wait.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             sel0,
  output logic             sel1,
  output logic             sel2,
  output logic             timeout
);

  if ((2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_hold_w
    $error("HOLD_W too narrow for MAX_HOLD");
  end

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             own_req;

  // Owner is masked out so a timeout handoff never re-picks the current owner.
  rr_pick8 u_pick (
    .req   (req & ~gnt_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              hold_expired;

  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OWN;
          gnt_d       = N_REQ'(1) << pick_idx;
          sel_d       = pick_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = pick_idx + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      OWN: begin
        if (own_req) begin
`ifdef ARB_TIMEOUT_EN
          if (hold_expired && pick_found) begin
            gnt_d     = N_REQ'(1) << pick_idx;
            sel_d     = pick_idx;
            ptr_d     = pick_idx + SEL_W'(1);
            hold_d    = '0;
            timeout_d = 1'b1;
          end else if (hold_q != '1) begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end else if (pick_found) begin
          // Handoff on the same edge the owner releases: no bubble.
          gnt_d = N_REQ'(1) << pick_idx;
          sel_d = pick_idx;
          ptr_d = pick_idx + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          hold_d = '0;
`endif
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign sel0      = sel_q[0];
  assign sel1      = sel_q[1];
  assign sel2      = sel_q[2];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       sel0, sel1, sel2;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  mux8_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] sel;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic v, input logic [2:0] s);
    vec_t e;
    e.req = r; e.gnt = g; e.vld = v; e.sel = s;
    tbl.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Rotation: each owner drops for one cycle, next in order takes over.
    add(8'hFF, 8'h01, 1, 0);
    add(8'hFE, 8'h02, 1, 1);
    add(8'hFD, 8'h04, 1, 2);
    add(8'hFB, 8'h08, 1, 3);
    add(8'hF7, 8'h10, 1, 4);
    add(8'hEF, 8'h20, 1, 5);
    add(8'hDF, 8'h40, 1, 6);
    add(8'hBF, 8'h80, 1, 7);
    add(8'h7F, 8'h01, 1, 0);
    // Wrap and priority: grant 6, release (ptr=7), then 7,0,1.
    add(8'h40, 8'h40, 1, 6);
    add(8'h00, 8'h00, 0, 0);
    add(8'h83, 8'h80, 1, 7);
    add(8'h03, 8'h01, 1, 0);
    add(8'h02, 8'h02, 1, 1);
    add(8'h00, 8'h00, 0, 0);
    // Idle return: 4-cycle req[3] pulse.
    add(8'h08, 8'h08, 1, 3);
    add(8'h08, 8'h08, 1, 3);
    add(8'h08, 8'h08, 1, 3);
    add(8'h08, 8'h08, 1, 3);
    add(8'h00, 8'h00, 0, 0);
    // Set up an owner of 5 for the async reset sequence.
    add(8'h20, 8'h20, 1, 5);

    rst_n = 1'b0;
    req   = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_gnt", gnt, 8'h00);
    check("reset_vld", {7'd0, gnt_valid}, 8'h00);
    check("reset_sel", {5'd0, sel2, sel1, sel0}, 8'h00);
    check("reset_timeout", {7'd0, timeout}, 8'h00);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req;
      cycle();
      check($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("vec%0d_vld", i), {7'd0, gnt_valid}, {7'd0, tbl[i].vld});
      if (tbl[i].vld)
        check($sformatf("vec%0d_sel", i), {5'd0, sel2, sel1, sel0}, {5'd0, tbl[i].sel});
      check($sformatf("vec%0d_timeout", i), {7'd0, timeout}, 8'h00);
    end

    // Async reset between edges while gnt=0x20.
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 8'h00);
    check("async_vld", {7'd0, gnt_valid}, 8'h00);
    check("async_sel", {5'd0, sel2, sel1, sel0}, 8'h00);
    check("async_timeout", {7'd0, timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h81;
    cycle();
    check("post_reset_prio_gnt", gnt, 8'h01);
    check("post_reset_prio_sel", {5'd0, sel2, sel1, sel0}, 8'h00);

    // Owner 0 drops; 2 and 5 held. ptr=1 so 2 wins.
    req = 8'h24;
    cycle();
    check("hold_first_gnt", gnt, 8'h04);
    for (int c = 1; c < 16; c++) begin
      cycle();
      check($sformatf("hold_c%0d_gnt", c), gnt, 8'h04);
      check($sformatf("hold_c%0d_timeout", c), {7'd0, timeout}, 8'h00);
    end
`ifdef ARB_TIMEOUT_EN
    cycle();
    check("to_gnt", gnt, 8'h20);
    check("to_pulse", {7'd0, timeout}, 8'h01);
    check("to_sel", {5'd0, sel2, sel1, sel0}, 8'h05);
    cycle();
    check("to_after_gnt", gnt, 8'h20);
    check("to_after_pulse", {7'd0, timeout}, 8'h00);
`else
    for (int c = 0; c < 8; c++) begin
      cycle();
      check($sformatf("nohold_c%0d_gnt", c), gnt, 8'h04);
      check($sformatf("nohold_c%0d_timeout", c), {7'd0, timeout}, 8'h00);
    end
`endif

    // Lone requester 5 held long: keeps grant, no timeout pulse.
    req = 8'h20;
    for (int c = 0; c < 40; c++) begin
      cycle();
      check($sformatf("lone_c%0d_gnt", c), gnt, 8'h20);
      check($sformatf("lone_c%0d_timeout", c), {7'd0, timeout}, 8'h00);
    end

    req = 8'h00;
    cycle();
    check("final_idle_gnt", gnt, 8'h00);
    check("final_idle_vld", {7'd0, gnt_valid}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
